// File: rtl/i2s_tx_pkg.sv
// Shared audio framing constants: frame/slot geometry and word-select encoding.
package i2s_tx_pkg;

    localparam int FRAME_BITS = 64;   // BCK periods per stereo frame
    localparam int SLOT_BITS  = 32;   // BCK periods per channel slot
    localparam int BITCNT_W   = 6;    // width of the in-frame bit counter

    // Word-select level for each channel
    typedef enum logic {
        WS_LEFT  = 1'b0,
        WS_RIGHT = 1'b1
    } ws_e;

    // Channel owning a given in-frame bit position
    function automatic ws_e ws_for_bit(input logic [BITCNT_W-1:0] bitcnt);
        return (int'(bitcnt) >= SLOT_BITS) ? WS_RIGHT : WS_LEFT;
    endfunction

endpackage

// File: rtl/i2s_bck_gen.sv
// Bit-clock generator: divides clk into BCK and flags the BCK falling-edge cycle.
module i2s_bck_gen #(
    parameter int BCK_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    output logic o_bck,
    output logic o_fall
);

    localparam int DIV_W = (BCK_DIV > 2) ? $clog2(BCK_DIV) : 1;

    logic [DIV_W-1:0] r_div;
    logic             r_bck;
    logic             w_tc;

    assign w_tc   = (r_div == DIV_W'(BCK_DIV - 1));
    assign o_bck  = r_bck;
    // The cycle in which BCK is about to drop is the only cycle serial state may move
    assign o_fall = w_tc && r_bck;

    // Divider counts a BCK half-period, toggling BCK at terminal count
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div <= '0;
            r_bck <= 1'b0;
        end else if (w_tc) begin
            r_div <= '0;
            r_bck <= ~r_bck;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

endmodule

// File: rtl/i2s_tx.sv
// Philips-format I2S transmitter with a one-pair holding buffer and valid/ready input.
//
// Input handshake: a pair transfers on any posedge where s_valid && s_ready.
// s_ready is high exactly when the holding buffer is empty and does not depend
// on s_valid. s_left/s_right are only captured on a transfer.
module i2s_tx
    import i2s_tx_pkg::*;
#(
    parameter int BCK_DIV  = 4,
    parameter int SAMPLE_W = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [SAMPLE_W-1:0] s_left,
    input  logic [SAMPLE_W-1:0] s_right,
    input  logic                mute,
    output logic                I2S_BCK,
    output logic                I2S_WS,
    output logic                I2S_DATA,
    output logic                frame_start,
    output logic                underrun
);

    logic                w_bck;
    logic                w_fall;
    logic                w_load;
    logic                w_xfer;
    logic [BITCNT_W-1:0] w_next_bitcnt;
    logic [4:0]          w_slot_k;
    logic [4:0]          w_bit_idx;
    logic [31:0]         w_sample_pad;
    logic                w_next_bit;

    logic [BITCNT_W-1:0] r_bitcnt;
    logic                r_ws;
    logic                r_data;
    logic                r_buf_full;
    logic [SAMPLE_W-1:0] r_buf_l;
    logic [SAMPLE_W-1:0] r_buf_r;
    logic [SAMPLE_W-1:0] r_frm_l;
    logic [SAMPLE_W-1:0] r_frm_r;

    i2s_bck_gen #(
        .BCK_DIV (BCK_DIV)
    ) u_bck_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .o_bck   (w_bck),
        .o_fall  (w_fall)
    );

    // A frame loads on the fall event that wraps the bit counter back to 0
    assign w_load        = w_fall && (r_bitcnt == BITCNT_W'(FRAME_BITS - 1));
    assign w_xfer        = s_valid && !r_buf_full;
    assign w_next_bitcnt = r_bitcnt + 1'b1;
    assign w_slot_k      = w_next_bitcnt[4:0];

    // Serial bit for the upcoming slot position: k=0 is the one-bit Philips delay,
    // k=1..SAMPLE_W carry MSB..LSB, everything after is zero padding
    always_comb begin
        w_bit_idx    = '0;
        w_sample_pad = '0;
        w_next_bit   = 1'b0;
        if ((w_slot_k != 5'd0) && (int'(w_slot_k) <= SAMPLE_W)) begin
            w_bit_idx    = 5'(SAMPLE_W - int'(w_slot_k));
            w_sample_pad = (ws_for_bit(w_next_bitcnt) == WS_RIGHT) ? 32'(r_frm_r) : 32'(r_frm_l);
            w_next_bit   = w_sample_pad[w_bit_idx];
        end
    end

    // Bit counter, word select and serial data advance together on fall events
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bitcnt <= BITCNT_W'(FRAME_BITS - 1);
            r_ws     <= 1'b0;
            r_data   <= 1'b0;
        end else if (w_fall) begin
            r_bitcnt <= w_next_bitcnt;
            r_ws     <= (ws_for_bit(w_next_bitcnt) == WS_RIGHT);
            r_data   <= w_next_bit;
        end
    end

    // Frame registers take the buffered pair at frame load; mute or empty loads silence
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_frm_l <= '0;
            r_frm_r <= '0;
        end else if (w_load) begin
            if (mute || !r_buf_full) begin
                r_frm_l <= '0;
                r_frm_r <= '0;
            end else begin
                r_frm_l <= r_buf_l;
                r_frm_r <= r_buf_r;
            end
        end
    end

    // Holding buffer: a transfer fills it, a frame load drains it; a transfer that
    // lands on a load cycle wins so the buffer stays full afterwards
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_buf_full <= 1'b0;
            r_buf_l    <= '0;
            r_buf_r    <= '0;
        end else if (w_xfer) begin
            r_buf_full <= 1'b1;
            r_buf_l    <= s_left;
            r_buf_r    <= s_right;
        end else if (w_load) begin
            r_buf_full <= 1'b0;
        end
    end

    assign s_ready     = !r_buf_full;
    assign I2S_BCK     = w_bck;
    assign I2S_WS      = r_ws;
    assign I2S_DATA    = r_data;
    assign frame_start = w_load;
    assign underrun    = w_load && !r_buf_full;

endmodule

// File: tb/tb_i2s_tx.sv
// Testbench for i2s_tx: directed phases with randomized data, checked against a
// cycle-count-based reference model of the I2S frame timing.
module tb_i2s_tx;

    localparam int BCK_DIV = 4;
    localparam int W       = 16;
    localparam int BP      = 2 * BCK_DIV;   // clk cycles per BCK period
    localparam int FRAME   = 64 * BP;       // clk cycles per frame

    logic         clk;
    logic         reset_n;
    logic         s_valid;
    logic         s_ready;
    logic [W-1:0] s_left;
    logic [W-1:0] s_right;
    logic         mute;
    logic         I2S_BCK;
    logic         I2S_WS;
    logic         I2S_DATA;
    logic         frame_start;
    logic         underrun;

    int checks;
    int failures;

    // reference model state
    int           cyc;        // posedges since reset release
    logic         m_full;
    logic [W-1:0] m_buf_l, m_buf_r;
    logic [W-1:0] m_frm_l, m_frm_r;

    // observation counters and captured serial words
    int           xfer_cnt;
    int           unr_cnt;
    logic [W-1:0] cap_l, cap_r;

    i2s_tx #(
        .BCK_DIV  (BCK_DIV),
        .SAMPLE_W (W)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_left      (s_left),
        .s_right     (s_right),
        .mute        (mute),
        .I2S_BCK     (I2S_BCK),
        .I2S_WS      (I2S_WS),
        .I2S_DATA    (I2S_DATA),
        .frame_start (frame_start),
        .underrun    (underrun)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        cyc     = 0;
        m_full  = 1'b0;
        m_buf_l = '0;
        m_buf_r = '0;
        m_frm_l = '0;
        m_frm_r = '0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_bck"},   32'(I2S_BCK),     32'd0);
        chk({tag, "_ws"},    32'(I2S_WS),      32'd0);
        chk({tag, "_data"},  32'(I2S_DATA),    32'd0);
        chk({tag, "_fs"},    32'(frame_start), 32'd0);
        chk({tag, "_unr"},   32'(underrun),    32'd0);
        chk({tag, "_ready"}, 32'(s_ready),     32'd1);
    endtask

    // Hold reset (already asserted) for a few cycles, then release at a negedge
    task automatic finish_reset(input string tag);
        s_valid = 1'b0;
        mute    = 1'b0;
        #1;
        chk_reset_outputs(tag);
        repeat (3) @(negedge clk);
        chk_reset_outputs({tag, "_hold"});
        model_clear();
        reset_n = 1'b1;
    endtask

    // One clk cycle: drive inputs at the negedge, check outputs against the model,
    // advance the model across the following posedge.
    task automatic cycle(input logic v, input logic [W-1:0] l, input logic [W-1:0] r, input logic m);
        int   nf, b, k;
        logic e_bck, e_ws, e_data, e_fs, e_unr, e_rdy, fall_now, xfer;
        logic [W-1:0] smp;
        s_valid = v;
        s_left  = l;
        s_right = r;
        mute    = m;
        #1;
        nf       = cyc / BP;                    // fall events completed so far
        e_bck    = ((cyc / BCK_DIV) % 2) == 1;
        fall_now = (cyc % BP) == (BP - 1);
        k        = 0;
        e_ws     = 1'b0;
        e_data   = 1'b0;
        if (nf >= 1) begin
            b    = (nf - 1) % 64;
            e_ws = (b >= 32);
            k    = b % 32;
            smp  = e_ws ? m_frm_r : m_frm_l;
            if (k >= 1 && k <= W) e_data = smp[W-k];
        end
        e_fs  = fall_now && ((nf % 64) == 0);
        e_unr = e_fs && !m_full;
        e_rdy = !m_full;
        chk("bck",         32'(I2S_BCK),     32'(e_bck));
        chk("ws",          32'(I2S_WS),      32'(e_ws));
        chk("data",        32'(I2S_DATA),    32'(e_data));
        chk("frame_start", 32'(frame_start), 32'(e_fs));
        chk("underrun",    32'(underrun),    32'(e_unr));
        chk("s_ready",     32'(s_ready),     32'(e_rdy));
        if ((cyc % BP) == 0 && nf >= 1 && k >= 1 && k <= W) begin
            if (e_ws) cap_r[W-k] = I2S_DATA;
            else      cap_l[W-k] = I2S_DATA;
        end
        if (s_valid && s_ready) xfer_cnt++;
        if (underrun) unr_cnt++;
        // model: frame load uses the buffer as it stood before this edge
        xfer = v && !m_full;
        if (e_fs) begin
            if (m || !m_full) begin
                m_frm_l = '0;
                m_frm_r = '0;
            end else begin
                m_frm_l = m_buf_l;
                m_frm_r = m_buf_r;
            end
        end
        if (xfer) begin
            m_buf_l = l;
            m_buf_r = r;
            m_full  = 1'b1;
        end else if (e_fs) begin
            m_full = 1'b0;
        end
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        xfer_cnt = 0;
        unr_cnt  = 0;
        cap_l    = '0;
        cap_r    = '0;
        reset_n  = 1'b0;
        s_valid  = 1'b0;
        s_left   = '0;
        s_right  = '0;
        mute     = 1'b0;
        model_clear();

        // power-on reset
        @(negedge clk);
        finish_reset("por");

        // pair pushed before the first frame load, then idle
        cycle(1'b1, 16'h8001, 16'h7FFE, 1'b0);
        while (cyc < FRAME + BP) cycle(1'b0, 16'($urandom), 16'($urandom), 1'b0);
        chk("first_left_word",  32'(cap_l), 32'h8001);
        chk("first_right_word", 32'(cap_r), 32'h7FFE);

        // two idle frames: one underrun per frame load
        unr_cnt = 0;
        repeat (2 * FRAME) cycle(1'b0, 16'($urandom), 16'($urandom), 1'b0);
        chk("idle_underruns", 32'(unr_cnt), 32'd2);

        // s_valid held high for three frames: one transfer per frame, no underrun
        xfer_cnt = 0;
        unr_cnt  = 0;
        repeat (3 * FRAME) cycle(1'b1, 16'($urandom), 16'($urandom), 1'b0);
        chk("stream_transfers", 32'(xfer_cnt), 32'd3);
        chk("stream_underruns", 32'(unr_cnt),  32'd0);

        // muted load of an all-ones pair: silence, buffer consumed, no underrun
        unr_cnt = 0;
        cap_l   = '1;
        cap_r   = '1;
        cycle(1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
        while ((cyc % FRAME) != BP) cycle(1'b0, 16'($urandom), 16'($urandom), 1'b1);
        chk("mute_underruns", 32'(unr_cnt), 32'd0);
        #1;
        chk("mute_ready", 32'(s_ready), 32'd1);
        repeat (FRAME) cycle(1'b0, 16'($urandom), 16'($urandom), 1'b0);
        chk("mute_left_word",  32'(cap_l), 32'h0000);
        chk("mute_right_word", 32'(cap_r), 32'h0000);

        // random traffic with occasional mute
        repeat (3 * FRAME) cycle(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                                 (($urandom_range(0, 3)) == 0));

        // transfer landing exactly on a load cycle with the buffer empty
        while (!(((cyc % FRAME) == (BP - 1)) && !m_full))
            cycle(1'b0, 16'($urandom), 16'($urandom), 1'b0);
        cycle(1'b1, 16'hA5C3, 16'h3C5A, 1'b0);
        #1;
        chk("coincide_ready", 32'(s_ready), 32'd0);
        cycle(1'b0, 16'($urandom), 16'($urandom), 1'b0);
        while ((cyc % FRAME) != (21 * BP + 2)) cycle(1'b0, 16'($urandom), 16'($urandom), 1'b0);

        // asynchronous reset in the middle of a frame (bit counter 20)
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        @(negedge clk);
        finish_reset("midrst_rel");
        while (cyc < BP - 1) cycle(1'b0, 16'($urandom), 16'($urandom), 1'b0);
        #1;
        chk("fresh_frame_start", 32'(frame_start), 32'd1);
        chk("fresh_underrun",    32'(underrun),    32'd1);
        while (cyc < FRAME + 2 * BP) cycle(1'b0, 16'($urandom), 16'($urandom), 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
